// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the loader/debug requester, the
// arbiter and the instr_mem macro port.
//   f_*  : fetch request/grant/response (read-only)
//   l_*  : loader request/grant/response (read/write, byte enables)
//   m_*  : memory port (1-cycle read latency, write-first)
// Modports: slave = arbiter view, master = requester/memory environment view.
interface imem_port_arbiter_if #(
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned DataBytes = DataWidth / 8
);
  logic                 f_req;
  logic [AddrWidth-1:0] f_addr;
  logic                 f_gnt;
  logic                 f_rvalid;
  logic [DataWidth-1:0] f_rdata;

  logic                 l_req;
  logic [AddrWidth-1:0] l_addr;
  logic [DataWidth-1:0] l_wdata;
  logic [DataBytes-1:0] l_wen;
  logic                 l_gnt;
  logic                 l_rvalid;
  logic [DataWidth-1:0] l_rdata;

  logic [AddrWidth-1:0] m_addr;
  logic [DataWidth-1:0] m_wdata;
  logic [DataBytes-1:0] m_wen;
  logic [DataWidth-1:0] m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, l_wen, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_addr, m_wdata, m_wen
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, l_wen, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_addr, m_wdata, m_wen
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous instruction-memory port between the fetch
// unit and the loader/debug requester. One access per cycle; read data comes
// back one cycle after grant, flagged to whichever side owned the access.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : imem_port_arbiter_if.slave (fetch, loader and memory signals)
// Build option IMEM_ARB_RR_EN:
//   undefined : fixed priority, loader wins conflicts unless fetch has been
//               denied MaxWait times in a row, then fetch wins
//   defined   : round-robin on conflict, alternating from the last granted side
module imem_port_arbiter #(
  parameter int unsigned Depth     = 2048,
  parameter int unsigned AddrWidth = $clog2(Depth),
  parameter int unsigned DataWidth = 64,
  parameter int unsigned DataBytes = DataWidth / 8,
  parameter int unsigned MaxWait   = 4
) (
  input logic                clk,
  input logic                rst_n,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OwnerNone, OwnerFetch, OwnerLoad} owner_e;

  owner_e owner_q, owner_d;
  logic   f_gnt, l_gnt;
  logic   conflict;

  logic [AddrWidth-1:0] addr_sel;
  logic [DataWidth-1:0] wdata_sel;
  logic [DataBytes-1:0] wen_sel;

  assign conflict = bus.f_req && bus.l_req;

`ifdef IMEM_ARB_RR_EN
  typedef enum logic {SideFetch, SideLoad} side_e;
  side_e last_q, last_d;
`else
  localparam int unsigned WaitWidth = $clog2(MaxWait + 1);
  logic [WaitWidth-1:0] wait_q, wait_d;
`endif

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (conflict) begin
`ifdef IMEM_ARB_RR_EN
        f_gnt = (last_q == SideLoad);
`else
        f_gnt = (wait_q == WaitWidth'(MaxWait));
`endif
        l_gnt = !f_gnt;
      end else begin
        f_gnt = bus.f_req;
        l_gnt = bus.l_req;
      end
    end
  end

  always_comb begin
    owner_d = OwnerNone;
    if (f_gnt) begin
      owner_d = OwnerFetch;
    end else if (l_gnt) begin
      owner_d = OwnerLoad;
    end
  end

`ifdef IMEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (f_gnt) begin
      last_d = SideFetch;
    end else if (l_gnt) begin
      last_d = SideLoad;
    end
  end
`else
  // Counts consecutive fetch denials; a dropped request forgets its history.
  always_comb begin
    wait_d = '0;
    if (bus.f_req && !f_gnt) begin
      wait_d = (wait_q == WaitWidth'(MaxWait)) ? wait_q : wait_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OwnerNone;
`ifdef IMEM_ARB_RR_EN
      last_q  <= SideFetch;
`else
      wait_q  <= '0;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef IMEM_ARB_RR_EN
      last_q  <= last_d;
`else
      wait_q  <= wait_d;
`endif
    end
  end

  // Idle port parks on the fetch address with writes disabled.
  assign addr_sel  = l_gnt ? bus.l_addr : bus.f_addr;
  assign wdata_sel = l_gnt ? bus.l_wdata : '0;
  assign wen_sel   = l_gnt ? bus.l_wen : '0;

  assign bus.f_gnt   = f_gnt;
  assign bus.l_gnt   = l_gnt;
  assign bus.m_addr  = addr_sel;
  assign bus.m_wdata = wdata_sel;
  assign bus.m_wen   = wen_sel;

  // rst_n gating drops the response of an access granted just before reset.
  assign bus.f_rvalid = rst_n && (owner_q == OwnerFetch);
  assign bus.l_rvalid = rst_n && (owner_q == OwnerLoad);
  assign bus.f_rdata  = bus.m_rdata;
  assign bus.l_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  imem_port_arbiter_if #(.AddrWidth(11), .DataWidth(64)) bus ();

  imem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural instr_mem: 1-cycle read latency, write-first.
  logic [63:0] mem [2048];
  logic [63:0] wr_word;
  logic        mem_ready = 1'b0;

  function automatic logic [63:0] init_word(input int unsigned a);
    return {16'hC0DE, a[15:0], ~a};
  endfunction

  always_comb begin
    wr_word = mem[bus.m_addr];
    for (int b = 0; b < 8; b++) begin
      if (bus.m_wen[b]) wr_word[b*8 +: 8] = bus.m_wdata[b*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
      mem_ready   <= 1'b1;
      bus.m_rdata <= '0;
    end else begin
      if (|bus.m_wen) mem[bus.m_addr] <= wr_word;
      bus.m_rdata <= wr_word;
    end
  end

  typedef struct {
    logic        f_req;
    logic [10:0] f_addr;
    logic        l_req;
    logic [10:0] l_addr;
    logic [63:0] l_wdata;
    logic [7:0]  l_wen;
    logic        e_fg;
    logic        e_lg;
    logic [10:0] e_maddr;
    logic [7:0]  e_mwen;
    logic        e_frv;
    logic        e_lrv;
    logic        chk_rd;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic fr, logic [10:0] fa, logic lr, logic [10:0] la,
                              logic [63:0] lwd, logic [7:0] lwe, logic efg, logic elg,
                              logic [10:0] ema, logic [7:0] emw, logic efrv, logic elrv,
                              logic chk, logic [63:0] erd);
    vec_t v;
    v.f_req = fr;   v.f_addr = fa;   v.l_req = lr;  v.l_addr = la;
    v.l_wdata = lwd; v.l_wen = lwe;  v.e_fg = efg;  v.e_lg = elg;
    v.e_maddr = ema; v.e_mwen = emw; v.e_frv = efrv; v.e_lrv = elrv;
    v.chk_rd = chk;  v.e_rdata = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [10:0] fa, input logic lr,
                       input logic [10:0] la, input logic [63:0] lwd, input logic [7:0] lwe);
    bus.f_req = fr; bus.f_addr = fa; bus.l_req = lr;
    bus.l_addr = la; bus.l_wdata = lwd; bus.l_wen = lwe;
  endtask

  logic [63:0] ones = '1;
  logic [63:0] wa   = 64'h1122334455667788;
  logic [63:0] wres = 64'hFFFFFFFF55667788;
  logic [63:0] wdb  = 64'hDEADBEEFCAFEF00D;

  initial begin
    // Fetch-only stream, then idle
    vq.push_back(mk(1, 11'h010, 0, 11'h000, 0, 8'h00, 1, 0, 11'h010, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(1, 11'h011, 0, 11'h000, 0, 8'h00, 1, 0, 11'h011, 8'h00, 1, 0, 1,
                    init_word(11'h010)));
    vq.push_back(mk(1, 11'h012, 0, 11'h000, 0, 8'h00, 1, 0, 11'h012, 8'h00, 1, 0, 1,
                    init_word(11'h011)));
    vq.push_back(mk(1, 11'h013, 0, 11'h000, 0, 8'h00, 1, 0, 11'h013, 8'h00, 1, 0, 1,
                    init_word(11'h012)));
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 1, 0, 1,
                    init_word(11'h013)));
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0));
    // Fetch loses a conflict then drops its request: no fetch response
    vq.push_back(mk(1, 11'h050, 1, 11'h051, 0, 8'h00, 0, 1, 11'h051, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 0, 1, 1,
                    init_word(11'h051)));
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0));
    // Loader writes: full word, then partial byte-enable merge, read back both ways
    vq.push_back(mk(0, 11'h000, 1, 11'h020, ones, 8'hFF, 0, 1, 11'h020, 8'hFF, 0, 0, 0, 0));
    vq.push_back(mk(0, 11'h000, 1, 11'h020, wa, 8'h0F, 0, 1, 11'h020, 8'h0F, 0, 1, 1, ones));
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 0, 1, 1, wres));
    vq.push_back(mk(1, 11'h020, 0, 11'h000, 0, 8'h00, 1, 0, 11'h020, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(1, 11'h030, 0, 11'h000, 0, 8'h00, 1, 0, 11'h030, 8'h00, 1, 0, 1, wres));
`ifdef IMEM_ARB_RR_EN
    // Both held: alternate starting with loader (last grant was fetch)
    for (int c = 0; c < 6; c++) begin
      logic lw;
      lw = (c % 2 == 0);
      vq.push_back(mk(1, 11'h030, 1, 11'h031, 0, 8'h00, !lw, lw, lw ? 11'h031 : 11'h030,
                      8'h00, lw, !lw, 1, lw ? init_word(11'h030) : init_word(11'h031)));
    end
`else
    // Both held 10 cycles: loader x4, fetch forced on the 5th, repeat
    for (int c = 0; c < 10; c++) begin
      logic fw;
      logic prev_f;
      fw     = (c % 5 == 4);
      prev_f = (c == 0) || (c == 5);
      vq.push_back(mk(1, 11'h030, 1, 11'h031, 0, 8'h00, fw, !fw, fw ? 11'h030 : 11'h031,
                      8'h00, prev_f, !prev_f, 1,
                      prev_f ? init_word(11'h030) : init_word(11'h031)));
    end
`endif
    vq.push_back(mk(0, 11'h000, 0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 8'h00, 1, 0, 1,
                    init_word(11'h030)));

    // Reset with requests pending: nothing granted, nothing written, no responses
    rst_n = 1'b0;
    drive(1, 11'h006, 1, 11'h005, ones, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst f_gnt", bus.f_gnt, 0);
      check("rst l_gnt", bus.l_gnt, 0);
      check("rst m_wen", bus.m_wen, 0);
      check("rst f_rvalid", bus.f_rvalid, 0);
      check("rst l_rvalid", bus.l_rvalid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].f_req, vq[i].f_addr, vq[i].l_req, vq[i].l_addr, vq[i].l_wdata, vq[i].l_wen);
      @(negedge clk);
      check($sformatf("v%0d f_gnt", i), bus.f_gnt, vq[i].e_fg);
      check($sformatf("v%0d l_gnt", i), bus.l_gnt, vq[i].e_lg);
      check($sformatf("v%0d m_addr", i), bus.m_addr, vq[i].e_maddr);
      check($sformatf("v%0d m_wen", i), bus.m_wen, vq[i].e_mwen);
      check($sformatf("v%0d f_rvalid", i), bus.f_rvalid, vq[i].e_frv);
      check($sformatf("v%0d l_rvalid", i), bus.l_rvalid, vq[i].e_lrv);
      if (vq[i].chk_rd) begin
        if (vq[i].e_frv) check($sformatf("v%0d f_rdata", i), bus.f_rdata, vq[i].e_rdata);
        else             check($sformatf("v%0d l_rdata", i), bus.l_rdata, vq[i].e_rdata);
      end
    end

    // Write granted in the cycle before reset asserts
    @(posedge clk); #1;
    drive(0, 0, 1, 11'h040, wdb, 8'hFF);
    @(negedge clk);
    check("pre-rst l_gnt", bus.l_gnt, 1);
    check("pre-rst m_wen", bus.m_wen, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1, 11'h040, 1, 11'h040, ones, 8'hFF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst2 l_rvalid", bus.l_rvalid, 0);
      check("rst2 f_gnt", bus.f_gnt, 0);
      check("rst2 l_gnt", bus.l_gnt, 0);
      check("rst2 m_wen", bus.m_wen, 0);
      if (c == 0) begin
        @(posedge clk); #1;
      end
    end
    // First conflict after reset goes to the loader
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 11'h040, 1, 11'h041, 0, 8'h00);
    @(negedge clk);
    check("post-rst conflict l_gnt", bus.l_gnt, 1);
    check("post-rst conflict f_gnt", bus.f_gnt, 0);
    @(posedge clk); #1;
    drive(1, 11'h040, 0, 0, 0, 0);
    @(negedge clk);
    check("post-rst f_gnt", bus.f_gnt, 1);
    check("post-rst l_rvalid", bus.l_rvalid, 1);
    check("post-rst l_rdata", bus.l_rdata, init_word(11'h041));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post-rst f_rvalid", bus.f_rvalid, 1);
    check("post-rst written word", bus.f_rdata, wdb);
    @(negedge clk);
    check("idle f_rvalid", bus.f_rvalid, 0);
    check("idle l_rvalid", bus.l_rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
